// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage 16-bit pipeline.
// It combines load-use hazards, branch mispredicts and main-memory wait
// into per-stage enables and bubble inserts. It also runs the halt drain
// and keeps saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_busy,
  input  logic             jump_pred_miss,
  input  logic             is_halt_ex,
  input  logic             from_main_mem_ex,
  input  logic             regwrite_ex,
  input  logic [2:0]       regwrite_adr_ex,
  input  logic [2:0]       rs_adr_id,
  input  logic [2:0]       rt_adr_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic             flush_memwb,
  output logic             flushed,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t     state;
  logic [2:0] drain_cnt;
  logic       loaduse;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // A load in EX whose destination feeds a source the ID instruction actually reads.
  assign loaduse = from_main_mem_ex & regwrite_ex &
                   ((uses_rs_id & (rs_adr_id == regwrite_adr_ex)) |
                    (uses_rt_id & (rt_adr_id == regwrite_adr_ex)));

  // Stage enables and bubble inserts, decoded from state and the current hazards.
  always_comb begin
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    en_idex     = 1'b1;
    en_exmem    = 1'b1;
    en_memwb    = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    flush_memwb = 1'b0;
    if (reset) begin
      en_pc       = 1'b0;
      en_ifid     = 1'b0;
      en_idex     = 1'b0;
      en_exmem    = 1'b0;
      en_memwb    = 1'b0;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
      flush_memwb = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
          end else if (jump_pred_miss) begin
            // Squash the two wrong-path instructions behind the branch.
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (loaduse || is_halt_ex) begin
            // Hold fetch/decode and send a bubble into EX.
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        end
        DRAIN: begin
          if (mem_busy) begin
            en_pc    = 1'b0;
            en_ifid  = 1'b0;
            en_idex  = 1'b0;
            en_exmem = 1'b0;
            en_memwb = 1'b0;
          end else begin
            // Only bubbles enter EX while the older instructions retire.
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end
        end
        default: begin
          en_pc    = 1'b0;
          en_ifid  = 1'b0;
          en_idex  = 1'b0;
          en_exmem = 1'b0;
          en_memwb = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, drain countdown, flush pulse, halt flag and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= 3'd0;
      flushed   <= 1'b0;
      halted    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      flushed <= 1'b0;
      case (state)
        RUN: begin
          if (mem_busy) begin
            stall_cnt <= sat_inc(stall_cnt);
          end else if (jump_pred_miss) begin
            flushed   <= 1'b1;
            flush_cnt <= sat_inc(flush_cnt);
          end else if (loaduse) begin
            stall_cnt <= sat_inc(stall_cnt);
          end else if (is_halt_ex) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          if (mem_busy) begin
            stall_cnt <= sat_inc(stall_cnt);
          end else if (drain_cnt <= 3'd1) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: begin
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (DRAIN_CYCLES = 3, CNT_W = 4).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset, mem_busy, jump_pred_miss, is_halt_ex;
  logic       from_main_mem_ex, regwrite_ex, uses_rs_id, uses_rt_id;
  logic [2:0] regwrite_adr_ex, rs_adr_id, rt_adr_id;
  logic       en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic       flushed, halted;
  logic [3:0] stall_cnt, flush_cnt;

  int vectors = 0;
  int miscompares = 0;

  pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mem_busy(mem_busy),
    .jump_pred_miss(jump_pred_miss), .is_halt_ex(is_halt_ex),
    .from_main_mem_ex(from_main_mem_ex), .regwrite_ex(regwrite_ex),
    .regwrite_adr_ex(regwrite_adr_ex), .rs_adr_id(rs_adr_id),
    .rt_adr_id(rt_adr_id), .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .flush_exmem(flush_exmem), .flush_memwb(flush_memwb),
    .flushed(flushed), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  wire [4:0] en_v = {en_pc, en_ifid, en_idex, en_exmem, en_memwb};
  wire [3:0] fl_v = {flush_ifid, flush_idex, flush_exmem, flush_memwb};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_busy = 0; jump_pred_miss = 0; is_halt_ex = 0;
    from_main_mem_ex = 0; regwrite_ex = 0; regwrite_adr_ex = 0;
    rs_adr_id = 0; rt_adr_id = 0; uses_rs_id = 0; uses_rt_id = 0;
  endtask

  task automatic set_loaduse(input logic use_rt);
    from_main_mem_ex = 1; regwrite_ex = 1; regwrite_adr_ex = 3'd3;
    uses_rt_id = use_rt; rt_adr_id = 3'd3;
    uses_rs_id = 1; rs_adr_id = 3'd5;
  endtask

  initial begin
    clear_in();
    reset = 1;
    // Reset held for two edges
    cyc(); #1;
    chk("rst_en", 8'(en_v), 8'h00);
    chk("rst_flush", 8'(fl_v), 8'h0F);
    cyc();
    reset = 0; #1;
    chk("run_en", 8'(en_v), 8'h1F);
    chk("run_flush", 8'(fl_v), 8'h00);
    chk("rst_stall", 8'(stall_cnt), 8'd0);
    chk("rst_fcnt", 8'(flush_cnt), 8'd0);
    chk("rst_halted", 8'(halted), 8'd0);

    // Load-use on rt
    set_loaduse(1); #1;
    chk("lu_en", 8'(en_v), 8'b00111);
    chk("lu_flush", 8'(fl_v), 8'b0100);
    cyc(); clear_in(); #1;
    chk("lu_after_en", 8'(en_v), 8'h1F);
    chk("lu_stall", 8'(stall_cnt), 8'd1);
    // Same registers but rt not read, rs differs: no hazard
    set_loaduse(0); #1;
    chk("nolu_en", 8'(en_v), 8'h1F);
    chk("nolu_flush", 8'(fl_v), 8'h00);
    cyc(); clear_in(); #1;
    chk("nolu_stall", 8'(stall_cnt), 8'd1);

    // Mispredict together with a load-use: mispredict wins
    set_loaduse(1); jump_pred_miss = 1; #1;
    chk("mp_en", 8'(en_v), 8'h1F);
    chk("mp_flush", 8'(fl_v), 8'b1100);
    cyc(); clear_in(); #1;
    chk("mp_flushed", 8'(flushed), 8'd1);
    chk("mp_fcnt", 8'(flush_cnt), 8'd1);
    chk("mp_stall", 8'(stall_cnt), 8'd1);
    cyc(); #1;
    chk("mp_flushed_off", 8'(flushed), 8'd0);

    // mem_busy for 4 cycles over a pending load-use
    set_loaduse(1); mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("busy_en", 8'(en_v), 8'h00);
      chk("busy_flush", 8'(fl_v), 8'h00);
      cyc();
    end
    chk("busy_stall", 8'(stall_cnt), 8'd5);
    mem_busy = 0; #1;
    chk("busy_lu_en", 8'(en_v), 8'b00111);
    chk("busy_lu_flush", 8'(fl_v), 8'b0100);
    cyc(); clear_in(); #1;
    chk("busy_lu_stall", 8'(stall_cnt), 8'd6);
    chk("busy_lu_after", 8'(en_v), 8'h1F);

    // Halt with an undisturbed 3-cycle drain
    is_halt_ex = 1; #1;
    chk("halt_en", 8'(en_v), 8'b00111);
    chk("halt_flush", 8'(fl_v), 8'b0100);
    cyc(); clear_in();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_en", 8'(en_v), 8'b00111);
      chk("drain_flush", 8'(fl_v), 8'b0100);
      chk("drain_halted", 8'(halted), 8'd0);
      cyc();
    end
    chk("halted", 8'(halted), 8'd1);
    chk("halted_en", 8'(en_v), 8'h00);
    chk("halted_flush", 8'(fl_v), 8'h00);
    cyc();
    chk("halted_hold", 8'(halted), 8'd1);

    // Reset out of HALTED
    reset = 1; cyc(); reset = 0; #1;
    chk("rerun_en", 8'(en_v), 8'h1F);
    chk("rerun_halted", 8'(halted), 8'd0);
    chk("rerun_stall", 8'(stall_cnt), 8'd0);

    // Halt with 2 busy cycles mid-drain and an ignored mispredict
    is_halt_ex = 1; cyc(); clear_in();
    #1;
    chk("d2_c1_en", 8'(en_v), 8'b00111);
    cyc();
    mem_busy = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("d2_busy_en", 8'(en_v), 8'h00);
      chk("d2_busy_flush", 8'(fl_v), 8'h00);
      cyc();
    end
    mem_busy = 0; jump_pred_miss = 1; #1;
    chk("d2_miss_ign", 8'(fl_v), 8'b0100);
    chk("d2_c2_halted", 8'(halted), 8'd0);
    cyc(); clear_in(); #1;
    chk("d2_no_flushed", 8'(flushed), 8'd0);
    chk("d2_c3_halted", 8'(halted), 8'd0);
    chk("d2_c3_en", 8'(en_v), 8'b00111);
    cyc();
    chk("d2_halted", 8'(halted), 8'd1);
    chk("d2_stall", 8'(stall_cnt), 8'd2);
    chk("d2_fcnt", 8'(flush_cnt), 8'd0);

    reset = 1; cyc(); reset = 0;

    // Halt and mispredict in the same cycle: stay in RUN
    is_halt_ex = 1; jump_pred_miss = 1; #1;
    chk("hm_flush", 8'(fl_v), 8'b1100);
    cyc(); clear_in(); #1;
    chk("hm_run_en", 8'(en_v), 8'h1F);
    cyc(); #1;
    chk("hm_still_run", 8'(en_v), 8'h1F);

    // 20 back-to-back mispredicts saturate the 4-bit counter
    jump_pred_miss = 1;
    for (int i = 0; i < 20; i++) cyc();
    clear_in(); #1;
    chk("sat_fcnt", 8'(flush_cnt), 8'd15);
    chk("sat_flushed", 8'(flushed), 8'd1);
    chk("sat_stall", 8'(stall_cnt), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
